// File: rtl/secded_decoder_72_64_if.sv
// Stream interface of the SECDED(72,64) decoder.
//   in_valid/in_ready/code_in      : codeword beat into the decoder
//   out_valid/out_ready            : result beat out of the decoder
//   data_out, err_ce, err_ue,
//   syndrome_out                   : result payload, qualified by out_valid
// slave  = decoder side, master = producer/consumer side.
interface secded_decoder_72_64_if #(
  parameter int DATA_W = 64,
  parameter int CODE_W = 72
);
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_ce;
  logic              err_ue;
  logic [7:0]        syndrome_out;

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, err_ce, err_ue, syndrome_out
  );

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, err_ce, err_ue, syndrome_out
  );
endinterface

// File: rtl/secded_decoder_72_64.sv
// Two-stage pipelined SECDED(72,64) decoder with error counters and a
// sticky first-uncorrectable log.
//   clk, rst_n       : clock, synchronous active-low reset
//   bus (slave)      : codeword in / corrected data + flags + syndrome out
//   cnt_clr_i        : synchronous clear of counters and UE log
//   cnt_ce_o/ue_o    : saturating corrected / uncorrectable beat counts
//   ue_seen_o        : sticky, a UE was loaded since reset/clear
//   ue_first_syn_o   : {p,s} of that first UE
module secded_decoder_72_64 #(
  parameter int DATA_W = 64,
  parameter int CODE_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  secded_decoder_72_64_if.slave bus,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_ce_o,
  output logic [CNT_W-1:0] cnt_ue_o,
  output logic             ue_seen_o,
  output logic [7:0]       ue_first_syn_o
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ce;
    logic              ue;
    logic [7:0]        syn;
  } res_t;

  logic              en, ld1, ld2;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [6:0][CODE_W-1:0] sel;
  logic [6:0]        syn_c;
  logic              par_c;
  logic [CODE_W-1:0] code_q, fixed;
  logic [6:0]        s_q;
  logic              p_q;
  res_t              res_d, res_q;
  logic [CNT_W-1:0]  cnt_ce_q, cnt_ce_d, cnt_ue_q, cnt_ue_d;
  logic              ue_seen_q, ue_seen_d;
  logic [7:0]        ue_first_q, ue_first_d;

  // Whole pipe advances only when the output slot is free or being drained.
  assign en           = ~vld_pipe_q[2] | bus.out_ready;
  assign bus.in_ready = en;
  assign ld1          = en & bus.in_valid;
  assign ld2          = en & vld_pipe_q[1];

  always_comb vld_pipe_d = en ? {vld_pipe_q[1], bus.in_valid} : vld_pipe_q;

  // Syndrome bit k covers every position whose index has bit k set;
  // position 0 (overall parity) never contributes.
  for (genvar k = 0; k < 7; k++) begin : g_syn
    for (genvar i = 0; i < CODE_W; i++) begin : g_bit
      assign sel[k][i] = ((i >> k) & 1) ? bus.code_in[i] : 1'b0;
    end
    assign syn_c[k] = ^sel[k];
  end
  assign par_c = ^bus.code_in;

  // Stage-2 decode from registered code/syndrome.
  always_comb begin
    fixed     = code_q;
    res_d     = '0;
    res_d.syn = {p_q, s_q};
    if (s_q == 7'd0) begin
      res_d.ce = p_q;                      // P0 itself flipped, data intact
    end else if (p_q && s_q <= 7'd71) begin
      res_d.ce = 1'b1;
      fixed    = code_q ^ (72'd1 << s_q);  // check-bit hits leave data intact
    end else begin
      res_d.ue = 1'b1;                     // double error or out-of-range position
    end
    res_d.data = {fixed[71:65], fixed[63:33], fixed[31:17],
                  fixed[15:9], fixed[7:5], fixed[3]};
  end

  // Counters and log track results as they enter stage 2; clear wins.
  always_comb begin
    cnt_ce_d   = cnt_ce_q;
    cnt_ue_d   = cnt_ue_q;
    ue_seen_d  = ue_seen_q;
    ue_first_d = ue_first_q;
    if (cnt_clr_i) begin
      cnt_ce_d   = '0;
      cnt_ue_d   = '0;
      ue_seen_d  = 1'b0;
      ue_first_d = '0;
    end else if (ld2) begin
      if (res_d.ce && !(&cnt_ce_q)) cnt_ce_d = cnt_ce_q + CNT_W'(1);
      if (res_d.ue && !(&cnt_ue_q)) cnt_ue_d = cnt_ue_q + CNT_W'(1);
      if (res_d.ue && !ue_seen_q) begin
        ue_seen_d  = 1'b1;
        ue_first_d = res_d.syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      code_q     <= '0;
      s_q        <= '0;
      p_q        <= 1'b0;
      res_q      <= '0;
      cnt_ce_q   <= '0;
      cnt_ue_q   <= '0;
      ue_seen_q  <= 1'b0;
      ue_first_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      if (ld1) begin
        code_q <= bus.code_in;
        s_q    <= syn_c;
        p_q    <= par_c;
      end
      if (ld2) res_q <= res_d;
      cnt_ce_q   <= cnt_ce_d;
      cnt_ue_q   <= cnt_ue_d;
      ue_seen_q  <= ue_seen_d;
      ue_first_q <= ue_first_d;
    end
  end

  assign bus.out_valid    = vld_pipe_q[2];
  assign bus.data_out     = res_q.data;
  assign bus.err_ce       = res_q.ce;
  assign bus.err_ue       = res_q.ue;
  assign bus.syndrome_out = res_q.syn;
  assign cnt_ce_o         = cnt_ce_q;
  assign cnt_ue_o         = cnt_ue_q;
  assign ue_seen_o        = ue_seen_q;
  assign ue_first_syn_o   = ue_first_q;
endmodule

// File: tb/tb_secded_decoder_72_64.sv
`timescale 1ns/1ps
module tb_secded_decoder_72_64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr;
  logic [15:0] cnt_ce, cnt_ue;
  logic        ue_seen;
  logic [7:0]  ue_first_syn;

  always #5 clk = ~clk;

  secded_decoder_72_64_if bus ();

  secded_decoder_72_64 dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .cnt_clr_i(cnt_clr), .cnt_ce_o(cnt_ce), .cnt_ue_o(cnt_ue),
    .ue_seen_o(ue_seen), .ue_first_syn_o(ue_first_syn)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        ce;
    logic        ue;
    logic [7:0]  syn;
  } exp_t;

  exp_t  q[$];
  exp_t  last;
  int    n_chk = 0, n_fail = 0;
  logic  bp_en = 1'b0, rdy_req = 1'b1;
  int    mdl_ce = 0, mdl_ue = 0;
  logic  mdl_seen = 1'b0;
  logic [7:0] mdl_first = '0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: syndrome = XOR of indices of set bits, data in non-power-of-two slots.
  function automatic exp_t model(input logic [71:0] c);
    exp_t e; int s; int j; logic p; logic [71:0] f;
    s = 0;
    for (int i = 1; i < 72; i++) if (c[i]) s = s ^ i;
    p = ^c; f = c; e = '0;
    if (s == 0) e.ce = p;
    else if (p && s < 72) begin e.ce = 1'b1; f[s] = ~f[s]; end
    else e.ue = 1'b1;
    j = 0;
    for (int i = 1; i < 72; i++)
      if ((i & (i - 1)) != 0) begin e.data[j] = f[i]; j++; end
    e.syn = {p, s[6:0]};
    return e;
  endfunction

  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] c; int j; int s;
    c = '0; j = 0; s = 0;
    for (int i = 1; i < 72; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[j]; j++; end
    for (int i = 1; i < 72; i++) if (c[i]) s = s ^ i;
    for (int k = 0; k < 7; k++) c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction

  // kind: 0 clean, 1 single error, 2 double error
  function automatic logic [71:0] rnd_code(input int kind);
    logic [71:0] c; int a, b;
    c = enc({$urandom, $urandom});
    a = $urandom_range(0, 71);
    if (kind >= 1) c[a] = ~c[a];
    if (kind == 2) begin
      b = (a + $urandom_range(1, 71)) % 72;
      c[b] = ~c[b];
    end
    return c;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_req;
    end
  end

  // Monitor: scoreboard, hold stability and ready rule, sampled mid-cycle.
  initial begin
    exp_t e; logic held; logic [63:0] h_d; logic [9:0] h_f;
    held = 1'b0; h_d = '0; h_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 1'b0;
      else begin
        if (held) begin
          check("hold_valid", 72'(bus.out_valid), 72'(1));
          check("hold_data", 72'(bus.data_out), 72'(h_d));
          check("hold_flags", 72'({bus.err_ce, bus.err_ue, bus.syndrome_out}), 72'(h_f));
        end
        check("in_ready", 72'(bus.in_ready), 72'(!bus.out_valid || bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) check("spurious_out", 72'(1), 72'(0));
          else begin
            e = q.pop_front();
            check("data", 72'(bus.data_out), 72'(e.data));
            check("ce", 72'(bus.err_ce), 72'(e.ce));
            check("ue", 72'(bus.err_ue), 72'(e.ue));
            check("syn", 72'(bus.syndrome_out), 72'(e.syn));
            last = e;
            if (e.ce && mdl_ce < 65535) mdl_ce++;
            if (e.ue && mdl_ue < 65535) mdl_ue++;
            if (e.ue && !mdl_seen) begin mdl_seen = 1'b1; mdl_first = e.syn; end
          end
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.code_in));
        held = bus.out_valid && !bus.out_ready;
        h_d  = bus.data_out;
        h_f  = {bus.err_ce, bus.err_ue, bus.syndrome_out};
      end
    end
  end

  task automatic send(input logic [71:0] c);
    logic acc;
    bus.in_valid = 1'b1; bus.code_in = c; acc = 1'b0;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 72'(0), 72'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    bus.in_valid = 1'b0; bp_en = 1'b0; rdy_req = 1'b1; ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk); #1;
      ok = (q.size() == 0) && !bus.out_valid;
    end
    if (!ok) check("drain_timeout", 72'(0), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_ce"}, 72'(cnt_ce), 72'(mdl_ce));
    check({tag, "_cnt_ue"}, 72'(cnt_ue), 72'(mdl_ue));
    check({tag, "_ue_seen"}, 72'(ue_seen), 72'(mdl_seen));
    check({tag, "_ue_first"}, 72'(ue_first_syn), 72'(mdl_first));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 72'(bus.out_valid), 72'(0));
    check({tag, "_data"}, 72'(bus.data_out), 72'(0));
    check({tag, "_flags"}, 72'({bus.err_ce, bus.err_ue, bus.syndrome_out}), 72'(0));
    check({tag, "_cnt"}, 72'({cnt_ce, cnt_ue}), 72'(0));
    check({tag, "_log"}, 72'({ue_seen, ue_first_syn}), 72'(0));
    check({tag, "_in_ready"}, 72'(bus.in_ready), 72'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bus.in_valid = 1'b0; bus.code_in = '0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean beats with latency check
    send(72'h0);
    @(negedge clk); check("lat_k", 72'(bus.out_valid), 72'(0));
    @(negedge clk); check("lat_k1", 72'(bus.out_valid), 72'(1));
    @(posedge clk); #1;
    send(72'h00F);
    @(negedge clk); check("lat2_k", 72'(bus.out_valid), 72'(0));
    @(negedge clk); check("lat2_k1", 72'(bus.out_valid), 72'(1));
    @(posedge clk); #1;
    drain();
    check("clean_data", 72'(last.data), 72'(64'h1));
    check("clean_flags", 72'({last.ce, last.ue, last.syn}), 72'(0));

    // Single errors: data bit 0 restored by correcting position 3
    send(72'h007); drain();
    check("se3_data", 72'(last.data), 72'(64'h1));
    check("se3_flags", 72'({last.ce, last.ue, last.syn}), 72'({2'b10, 8'h83}));
    send(72'h001); drain();
    check("se0_data", 72'(last.data), 72'(64'h0));
    check("se0_flags", 72'({last.ce, last.ue, last.syn}), 72'({2'b10, 8'h80}));
    check("se_cnt_ce", 72'(cnt_ce), 72'(2));

    // Double and invalid-position errors
    send(72'h220); drain();
    check("de_flags", 72'({last.ce, last.ue, last.syn}), 72'({2'b01, 8'h0C}));
    check("de_log", 72'({ue_seen, ue_first_syn}), 72'({1'b1, 8'h0C}));
    send(72'h01_0000_0000_0000_0108); drain();
    check("inv_flags", 72'({last.ce, last.ue, last.syn}), 72'({2'b01, 8'hCB}));
    check("inv_log", 72'({ue_seen, ue_first_syn}), 72'({1'b1, 8'h0C}));
    check("inv_cnt_ue", 72'(cnt_ue), 72'(2));

    // Back-to-back mixed traffic
    for (int i = 0; i < 60; i++) send(rnd_code($urandom_range(0, 2)));
    drain();
    check_counters("mix");

    // Backpressure: 8 single-error beats then mixed, random out_ready
    bp_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      kind = (i < 8) ? 1 : $urandom_range(0, 2);
      send(rnd_code(kind));
    end
    drain();
    check_counters("bp");

    // Saturation of the UE counter
    for (int i = 0; i < 65536 + 3; i++) send(rnd_code(2));
    drain();
    check("sat_cnt_ue", 72'(cnt_ue), 72'(16'hFFFF));
    check_counters("sat");

    // Clear on the same edge a UE loads into stage 2
    send(rnd_code(2));
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    drain();
    check("clr_beat_ue", 72'(last.ue), 72'(1));
    mdl_ce = 0; mdl_ue = 0; mdl_seen = 1'b0; mdl_first = '0;
    check_counters("clr");
    send(rnd_code(2)); send(rnd_code(1)); drain();
    check_counters("post_clr");

    // Reset with both stages full and output stalled
    rdy_req = 1'b0;
    @(posedge clk); #1;
    send(rnd_code(1)); send(rnd_code(2));
    bus.in_valid = 1'b1; bus.code_in = rnd_code(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_valid = 1'b0;
    q.delete();
    mdl_ce = 0; mdl_ue = 0; mdl_seen = 1'b0; mdl_first = '0;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1;
    rdy_req = 1'b1;
    send(rnd_code(1)); send(rnd_code(0)); drain();
    check_counters("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
